vector_element_sequencer: RTL and testbench

- Steps through the active elements of one vector-register operand, one element per accepted handshake.
- For each element it produces:
  - the 32-bit word address inside the VLEN-bit register,
  - the byte lane and byte enables,
  - the end-of-word flag and the last-element flag.
- Sits between the vector issue/decode logic (start, vl, SEW) and the word-serial VRF/ALU datapath. Its address decoding matches the team's 32-bit alignment decoder.

---
 rtl/vector_element_sequencer.sv | 136 +++++++++++++
 tb/tb_vector_element_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vector_element_sequencer.sv
// Walks the active elements of one vector register operand, presenting one element per
// accepted handshake with its 32-bit word address, byte lane/enables and end-of-word/last flags.
module vector_element_sequencer #(
  parameter int VLEN = 256,
  localparam int EW = $clog2(VLEN/8),
  localparam int AW = $clog2(VLEN/32)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [EW:0]   i_vl,
  input  logic [2:0]    i_width,
  input  logic          i_abort,
  output logic          o_busy,
  output logic          o_elem_valid,
  input  logic          i_elem_ready,
  output logic [EW-1:0] o_elem_idx,
  output logic [AW-1:0] o_word_addr,
  output logic [1:0]    o_byte_lane,
  output logic [3:0]    o_byte_en,
  output logic          o_word_last,
  output logic          o_last_elem,
  output logic          o_done,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // sew_q encodes element size as log2(bytes): 0=8b, 1=16b, 2=32b
  localparam logic [EW:0]   VLMAX8 = (EW+1)'(VLEN/8);
  localparam logic [EW-1:0] IDX_ONE = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW:0]   CNT_ONE = {{EW{1'b0}}, 1'b1};

  state_t        state;
  logic [EW-1:0] idx_q;
  logic [1:0]    sew_q;
  logic [EW:0]   cnt_q;

  logic [1:0]    start_sew;
  logic [EW:0]   start_vlmax;
  logic [EW:0]   start_n;
  logic          is_last;

  always_comb begin
    case (i_width)
      3'b101:  start_sew = 2'd1;
      3'b110:  start_sew = 2'd2;
      default: start_sew = 2'd0;
    endcase
    start_vlmax = VLMAX8 >> start_sew;
    start_n     = (i_vl > start_vlmax) ? start_vlmax : i_vl;
    is_last     = ({1'b0, idx_q} == (cnt_q - CNT_ONE));
  end

  // Handshake: an element transfers on a rising edge where o_elem_valid & i_elem_ready.
  // While valid is high and ready is low, every element output holds steady; valid
  // never drops without a transfer except on i_abort, which ends the operation.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      idx_q <= '0;
      sew_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            sew_q <= start_sew;
            cnt_q <= start_n;
            idx_q <= '0;
            state <= (start_n != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (i_abort) begin
            state <= DONE;
          end else if (i_elem_ready) begin
            if (is_last) state <= DONE;
            else         idx_q <= idx_q + IDX_ONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy  = (state == RUN);
  assign o_done  = (state == DONE);
  assign o_state = state;

  always_comb begin
    o_elem_valid = 1'b0;
    o_elem_idx   = '0;
    o_word_addr  = '0;
    o_byte_lane  = '0;
    o_byte_en    = '0;
    o_word_last  = 1'b0;
    o_last_elem  = 1'b0;
    if (state == RUN) begin
      o_elem_valid = 1'b1;
      o_elem_idx   = idx_q;
      o_last_elem  = is_last;
      case (sew_q)
        2'd0: begin
          o_word_addr = idx_q[EW-1:2];
          o_byte_lane = idx_q[1:0];
          o_byte_en   = 4'b0001 << idx_q[1:0];
          o_word_last = &idx_q[1:0];
        end
        2'd1: begin
          o_word_addr = idx_q[EW-2:1];
          o_byte_lane = {idx_q[0], 1'b0};
          o_byte_en   = 4'b0011 << {idx_q[0], 1'b0};
          o_word_last = idx_q[0];
        end
        2'd2: begin
          o_word_addr = idx_q[AW-1:0];
          o_byte_lane = 2'd0;
          o_byte_en   = 4'b1111;
          o_word_last = 1'b1;
        end
        default: begin
          o_word_addr = '0;
        end
      endcase
      // A partial final word still has to be flushed downstream.
      if (is_last) o_word_last = 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Bench for vector_element_sequencer: directed and random operations checked against an
// arithmetic model of the element-to-byte mapping, with a queue of expected elements.
module tb_vector_element_sequencer;

  localparam int VLEN = 256;
  localparam int EW   = $clog2(VLEN/8);
  localparam int AW   = $clog2(VLEN/32);

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic [EW:0]   i_vl;
  logic [2:0]    i_width;
  logic          i_abort;
  logic          o_busy;
  logic          o_elem_valid;
  logic          i_elem_ready;
  logic [EW-1:0] o_elem_idx;
  logic [AW-1:0] o_word_addr;
  logic [1:0]    o_byte_lane;
  logic [3:0]    o_byte_en;
  logic          o_word_last;
  logic          o_last_elem;
  logic          o_done;
  logic [1:0]    o_state;

  vector_element_sequencer #(.VLEN(VLEN)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_vl(i_vl),
    .i_width(i_width), .i_abort(i_abort), .o_busy(o_busy),
    .o_elem_valid(o_elem_valid), .i_elem_ready(i_elem_ready),
    .o_elem_idx(o_elem_idx), .o_word_addr(o_word_addr),
    .o_byte_lane(o_byte_lane), .o_byte_en(o_byte_en),
    .o_word_last(o_word_last), .o_last_elem(o_last_elem),
    .o_done(o_done), .o_state(o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sew_bytes(input logic [2:0] w);
    if (w == 3'b101) return 2;
    if (w == 3'b110) return 4;
    return 1;
  endfunction

  // Element fields packed as idx<<16 | word<<8 | lane<<6 | byte_en<<2 | word_last<<1 | last
  function automatic logic [31:0] pack(input int idx, input int word, input int lane,
                                       input int be, input int wl, input int le);
    return 32'((idx << 16) | (word << 8) | (lane << 6) | (be << 2) | (wl << 1) | le);
  endfunction

  function automatic logic [31:0] model_elem(input int i, input int sb, input int n);
    int byte_off, lane, be, wl, le;
    byte_off = i * sb;
    lane     = byte_off % 4;
    be       = ((1 << sb) - 1) << lane;
    le       = (i == n - 1) ? 1 : 0;
    wl       = ((lane + sb) == 4 || le == 1) ? 1 : 0;
    return pack(i, byte_off / 4, lane, be, wl, le);
  endfunction

  function automatic logic [31:0] dut_elem();
    return pack(int'(o_elem_idx), int'(o_word_addr), int'(o_byte_lane),
                int'(o_byte_en), int'(o_word_last), int'(o_last_elem));
  endfunction

  // driver: one complete operation, checked element by element
  task automatic run_op(input logic [2:0] w, input int vl, input int ready_pct,
                        input int abort_idx, input bit abort_rdy, input bit hold_start);
    int sb, vlmax, n, acc, exp_acc, cycles;
    bit fin, ab;
    sb    = sew_bytes(w);
    vlmax = VLEN / (8 * sb);
    n     = (vl < vlmax) ? vl : vlmax;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(model_elem(i, sb, n));
    exp_acc = (abort_idx >= 0 && abort_idx < n) ? abort_idx + int'(abort_rdy) : n;

    @(negedge i_clk);
    i_start = 1'b1; i_vl = (EW+1)'(vl); i_width = w;
    i_elem_ready = 1'b0; i_abort = 1'b0;
    @(posedge i_clk);
    #1 i_start = hold_start;

    acc = 0; fin = 1'b0; cycles = 0;
    while (!fin && cycles < 2000) begin
      @(negedge i_clk);
      cycles++;
      if (o_elem_valid) begin
        check("busy_run", o_busy, 1);
        if (exp_q.size() == 0) begin
          check("elem_overrun", acc, n + 1);
          fin = 1'b1;
        end else begin
          check("elem", dut_elem(), exp_q[0]);
          ab = (abort_idx >= 0) && (acc == abort_idx);
          i_abort = ab;
          i_elem_ready = ab ? abort_rdy : ($urandom_range(0, 99) < ready_pct);
          if (i_elem_ready) begin
            acc++;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        i_abort = 1'b0; i_elem_ready = 1'b0;
        check("done_pulse", o_done, 1);
        check("idle_elem_zero", dut_elem(), 0);
        check("busy_in_done", o_busy, 0);
        if (ready_pct == 100 && abort_idx < 0) check("latency", cycles, n + 1);
        fin = 1'b1;
      end
    end
    if (!fin) check("timeout", cycles, 0);
    check("accepted", acc, exp_acc);

    @(posedge i_clk);
    #1 i_start = 1'b0;
    @(negedge i_clk);
    check("done_once", o_done, 0);
    check("no_restart", o_busy, 0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_vl = '0; i_width = '0;
    i_abort = 1'b0; i_elem_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_elem", dut_elem(), 0);
    check("rst_valid", o_elem_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_state", o_state, 0);
    i_rst_n = 1'b1;

    // reset mid-run: 8b, vl=20, stop at index 7
    @(negedge i_clk);
    i_start = 1'b1; i_vl = (EW+1)'(20); i_width = 3'b000;
    @(posedge i_clk);
    #1 i_start = 1'b0; i_elem_ready = 1'b1;
    repeat (7) @(posedge i_clk);
    @(negedge i_clk);
    check("pre_rst_elem", dut_elem(), model_elem(7, 1, 20));
    i_rst_n = 1'b0; i_elem_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("midrst_elem", dut_elem(), 0);
    check("midrst_valid", o_elem_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_state", o_state, 0);
    i_rst_n = 1'b1;
    run_op(3'b000, 5, 100, -1, 1'b0, 1'b0);

    // directed cases
    run_op(3'b000, 32, 100, -1, 1'b0, 1'b0);   // 8b full register
    run_op(3'b101, 40, 50, -1, 1'b0, 1'b0);    // 16b clamp to 16, backpressure
    run_op(3'b110, 3, 100, -1, 1'b0, 1'b0);    // 32b short
    run_op(3'b000, 6, 100, -1, 1'b0, 1'b0);    // 8b odd tail
    run_op(3'b000, 0, 100, -1, 1'b0, 1'b0);    // vl=0
    run_op(3'b011, 4, 100, -1, 1'b0, 1'b0);    // illegal width acts as 8b
    run_op(3'b000, 10, 100, 4, 1'b0, 1'b0);    // abort at index 4, ready low
    run_op(3'b101, 10, 100, 6, 1'b1, 1'b0);    // abort with coincident handshake
    run_op(3'b000, 8, 70, -1, 1'b0, 1'b1);     // start held through RUN and DONE
    run_op(3'b110, 63, 100, -1, 1'b0, 1'b0);   // 32b clamp to 8

    // random operations
    for (int k = 0; k < 30; k++) begin
      logic [2:0] w;
      int ab_idx;
      case ($urandom_range(0, 3))
        0:       w = 3'b000;
        1:       w = 3'b101;
        2:       w = 3'b110;
        default: w = 3'($urandom_range(0, 7));
      endcase
      ab_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_op(w, int'($urandom_range(0, (1 << (EW + 1)) - 1)), int'($urandom_range(30, 100)),
             ab_idx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
